// File: rtl/mem_store_unit_pkg.sv
// Shared store-path types: bus store codes, FSM state encoding, size helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_store_unit_pkg;

   typedef logic [2:0] bus_s_code_t;

   localparam bus_s_code_t STORE_NOPE = 3'b000;
   localparam bus_s_code_t INSTR_SB   = 3'b001;
   localparam bus_s_code_t INSTR_SH   = 3'b010;
   localparam bus_s_code_t INSTR_SW   = 3'b011;
   localparam bus_s_code_t INSTR_SD   = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT0 = 2'd1,
      ST_BEAT1 = 2'd2
   } st_state_e;

   // Store size in bytes; 0 marks a code that is not a store.
   function automatic logic [3:0] store_nbytes(input bus_s_code_t code);
      case (code)
         INSTR_SB: return 4'd1;
         INSTR_SH: return 4'd2;
         INSTR_SW: return 4'd4;
         INSTR_SD: return 4'd8;
         default:  return 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/mem_store_unit_if.sv
// Store request + data-memory write port bundle between pipeline, unit and memory.
// Latency: n/a (wires only).
// Backpressure: st_ready_o gates requests, mem_ack_i advances beats.
interface mem_store_unit_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
) ();
   import mem_store_unit_pkg::*;

   logic                  st_valid_i;
   logic                  st_ready_o;
   bus_s_code_t           st_code_i;
   logic [ADDR_WIDTH-1:0] st_addr_i;
   logic [DATA_WIDTH-1:0] st_data_i;
   logic                  hold_n_o;
   logic                  mem_req_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [DATA_WIDTH-1:0] mem_wdata_o;
   logic [7:0]            mem_wstrb_o;
   logic                  mem_ack_i;
   logic                  st_done_o;

   // The store unit side.
   modport slave (
      input  st_valid_i, st_code_i, st_addr_i, st_data_i, mem_ack_i,
      output st_ready_o, hold_n_o, mem_req_o, mem_addr_o, mem_wdata_o,
             mem_wstrb_o, st_done_o
   );

   // The pipeline/memory side driving the unit.
   modport master (
      output st_valid_i, st_code_i, st_addr_i, st_data_i, mem_ack_i,
      input  st_ready_o, hold_n_o, mem_req_o, mem_addr_o, mem_wdata_o,
             mem_wstrb_o, st_done_o
   );
endinterface

// File: rtl/mem_store_unit_store_align.sv
// Places right-justified store data on byte lanes across two 8-byte words.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; vld_o low for codes that are not stores.
module store_align
   import mem_store_unit_pkg::*;
(
   input  bus_s_code_t   code_i,
   input  logic [2:0]    off_i,
   input  logic [63:0]   data_i,
   output logic [127:0]  sh128_o,
   output logic [15:0]   sb16_o,
   output logic          vld_o
);
   logic [3:0]  nbytes;
   logic [7:0]  byte_mask;
   logic [63:0] data_mask;

   // Build the n-byte mask, then shift data and strobes up by the byte offset.
   always_comb begin
      nbytes    = store_nbytes(code_i);
      vld_o     = (nbytes != 4'd0);
      byte_mask = 8'h00;
      case (nbytes)
         4'd1:    byte_mask = 8'h01;
         4'd2:    byte_mask = 8'h03;
         4'd4:    byte_mask = 8'h0F;
         4'd8:    byte_mask = 8'hFF;
         default: byte_mask = 8'h00;
      endcase
      data_mask = '0;
      for (int i = 0; i < 8; i++) begin
         data_mask[8*i +: 8] = {8{byte_mask[i]}};
      end
      sh128_o = {64'd0, data_i & data_mask} << {off_i, 3'b000};
      sb16_o  = {8'h00, byte_mask} << off_i;
   end
endmodule

// File: rtl/mem_store_unit.sv
// Store unit: aligns SB/SH/SW/SD onto a 64-bit strobed write port, splitting boundary-crossers.
// Latency: mem_req_o the cycle after accept; st_done_o one cycle after the final mem_ack_i.
// Backpressure: st_ready_o/hold_n_o low while busy; each beat holds until mem_ack_i.
module mem_store_unit
   import mem_store_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
) (
   input  logic               clk,
   input  logic               rst,
   mem_store_unit_if.slave    bus
);
   st_state_e               state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   hi_wdata_q, hi_wdata_d;
   logic [7:0]              wstrb_q, wstrb_d;
   logic [7:0]              hi_wstrb_q, hi_wstrb_d;
   logic                    done_q, done_d;

   logic [2*DATA_WIDTH-1:0] sh128;
   logic [15:0]             sb16;
   logic                    code_vld;
   logic                    accept;

   store_align u_align (
      .code_i  (bus.st_code_i),
      .off_i   (bus.st_addr_i[2:0]),
      .data_i  (bus.st_data_i),
      .sh128_o (sh128),
      .sb16_o  (sb16),
      .vld_o   (code_vld)
   );

   assign accept = (state_q == ST_IDLE) && bus.st_valid_i && code_vld;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Beat registers and done flag; all cleared by reset so idle outputs read zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         hi_wdata_q <= '0;
         hi_wstrb_q <= '0;
         done_q     <= 1'b0;
      end else begin
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         hi_wdata_q <= hi_wdata_d;
         hi_wstrb_q <= hi_wstrb_d;
         done_q     <= done_d;
      end
   end

   // Next state and beat contents: load both halves at accept, swap in the upper half on split.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      hi_wdata_d = hi_wdata_q;
      hi_wstrb_d = hi_wstrb_q;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d    = ST_BEAT0;
               addr_d     = {bus.st_addr_i[ADDR_WIDTH-1:3], 3'b000};
               wdata_d    = sh128[DATA_WIDTH-1:0];
               wstrb_d    = sb16[7:0];
               hi_wdata_d = sh128[2*DATA_WIDTH-1:DATA_WIDTH];
               hi_wstrb_d = sb16[15:8];
            end
         end
         ST_BEAT0: begin
            if (bus.mem_ack_i) begin
               if (hi_wstrb_q != 8'h00) begin
                  state_d = ST_BEAT1;
                  addr_d  = addr_q + ADDR_WIDTH'(8);
                  wdata_d = hi_wdata_q;
                  wstrb_d = hi_wstrb_q;
               end else begin
                  state_d    = ST_IDLE;
                  addr_d     = '0;
                  wdata_d    = '0;
                  wstrb_d    = '0;
                  hi_wdata_d = '0;
                  hi_wstrb_d = '0;
                  done_d     = 1'b1;
               end
            end
         end
         ST_BEAT1: begin
            if (bus.mem_ack_i) begin
               state_d    = ST_IDLE;
               addr_d     = '0;
               wdata_d    = '0;
               wstrb_d    = '0;
               hi_wdata_d = '0;
               hi_wstrb_d = '0;
               done_d     = 1'b1;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            addr_d     = '0;
            wdata_d    = '0;
            wstrb_d    = '0;
            hi_wdata_d = '0;
            hi_wstrb_d = '0;
         end
      endcase
   end

   assign bus.st_ready_o  = (state_q == ST_IDLE);
   assign bus.hold_n_o    = (state_q == ST_IDLE);
   assign bus.mem_req_o   = (state_q != ST_IDLE);
   assign bus.mem_addr_o  = addr_q;
   assign bus.mem_wdata_o = wdata_q;
   assign bus.mem_wstrb_o = wstrb_q;
   assign bus.st_done_o   = done_q;

endmodule
